// File: rtl/key_scan_16.sv
// 16-key matrix scanner: one key strobed per SCAN_DIV-cycle slot, single-key debounce,
// press events out on valid/ready; an event arriving while the output is occupied is dropped and flagged.
module key_scan_16 #(
  parameter int SCAN_DIV = 1000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       key_sense,
  output logic [3:0] scan_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_SCANS + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DB   = CW'(DB_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    scan_idx_q, scan_idx_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          overflow_q, overflow_d;

  logic          ks, sample, hit, emit;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    sync1_d    = key_sense;
    sync2_d    = sync1_q;
    ks         = sync2_q;
    sample     = en && (tmr_q == TMR_LAST);
    hit        = (scan_idx_q == cap_q);
    cnt_inc    = cnt_q + CNT_ONE;
    tmr_d      = tmr_q;
    scan_idx_d = scan_idx_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    emit       = 1'b0;

    if (en) begin
      if (tmr_q == TMR_LAST) begin
        tmr_d      = '0;
        scan_idx_d = scan_idx_q + 4'd1;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end

    // Once a key is tracked, samples for every other index are ignored.
    if (sample) begin
      case (state_q)
        IDLE: begin
          if (ks) begin
            cap_d = scan_idx_q;
            cnt_d = CNT_ONE;
            if (DB_SCANS == 1) begin
              emit    = 1'b1;
              state_d = HELD;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (hit) begin
            if (ks) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_DB) begin
                emit    = 1'b1;
                state_d = HELD;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (hit && !ks) begin
            cnt_d   = CNT_ONE;
            state_d = (DB_SCANS == 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (hit) begin
            if (!ks) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_DB) state_d = IDLE;
            end else begin
              state_d = HELD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overflow_d  = 1'b0;
    if (emit) begin
      if (key_valid_q && !key_ready) begin
        overflow_d = 1'b1;
      end else begin
        key_code_d  = cap_d;
        key_valid_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      tmr_q       <= '0;
      scan_idx_q  <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tmr_q       <= tmr_d;
      scan_idx_q  <= scan_idx_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign scan_idx  = scan_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_scan_16.sv
// Bench for key_scan_16: directed scenarios plus randomized key matrix traffic, checked every cycle
// against a slot-level reference model.
module tb_key_scan_16;
  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 16 * SD;

  logic       clk = 1'b0, reset = 1'b1, en = 1'b1, key_sense = 1'b0, key_ready = 1'b0;
  logic [3:0] scan_idx, key_code;
  logic       key_valid, overflow;

  key_scan_16 #(.SCAN_DIV(SD), .DB_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .en(en), .key_sense(key_sense),
    .scan_idx(scan_idx), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Key matrix: the strobed key's state is presented once per slot, just after the index moves.
  logic [15:0] pressed = '0;
  logic [3:0]  last_idx = 4'd0;
  always @(negedge clk) begin
    if (reset || scan_idx !== last_idx) key_sense <= pressed[scan_idx];
    last_idx <= scan_idx;
  end

  // Reference model: one step per clock, one debounce decision per slot end.
  typedef struct {
    int idx, tmr, trk, streak, rel, code;
    bit conf, valid, ovf;
  } model_t;
  model_t m;

  function automatic model_t m_reset();
    model_t r;
    r.idx = 0; r.tmr = 0; r.trk = -1; r.streak = 0; r.rel = 0; r.code = 0;
    r.conf = 0; r.valid = 0; r.ovf = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, bit e, bit s, bit rdy);
    model_t n = c;
    bit emit = 0;
    if (e) begin
      if (c.tmr == SD - 1) begin
        n.tmr = 0;
        n.idx = (c.idx + 1) % 16;
        if (c.trk < 0) begin
          if (s) begin
            n.trk = c.idx; n.streak = 1; n.rel = 0;
            n.conf = (DB <= 1); emit = (DB <= 1);
          end
        end else if (c.idx == c.trk) begin
          if (!c.conf) begin
            if (s) begin
              n.streak = c.streak + 1;
              if (n.streak >= DB) begin n.conf = 1; emit = 1; end
            end else n.trk = -1;
          end else if (s) n.rel = 0;
          else begin
            n.rel = c.rel + 1;
            if (n.rel >= DB) n.trk = -1;
          end
        end
      end else n.tmr = c.tmr + 1;
    end
    n.ovf = 0;
    if (emit) begin
      if (c.valid && !rdy) n.ovf = 1;
      else begin n.valid = 1; n.code = n.trk; end
    end else if (c.valid && rdy) n.valid = 0;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= m_reset();
    else       m <= step(m, en, key_sense, key_ready);
  end

  bit run = 0;
  always @(negedge clk) begin
    if (run) begin
      chk("scan_idx",  scan_idx,  m.idx);
      chk("key_valid", key_valid, m.valid);
      chk("key_code",  key_code,  m.code);
      chk("overflow",  overflow,  m.ovf);
    end
  end

  int n_acc = 0, n_ovf = 0, n_vld = 0;
  logic [3:0] acc_code = 4'd0;
  always @(posedge clk) begin
    if (run && !reset) begin
      if (key_valid && key_ready) begin
        n_acc    <= n_acc + 1;
        acc_code <= key_code;
      end
      if (overflow)  n_ovf <= n_ovf + 1;
      if (key_valid) n_vld <= n_vld + 1;
    end
  end

  task automatic scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic restart(input logic [15:0] keys);
    @(negedge clk); #2 reset = 1'b1;
    pressed = keys;
    @(negedge clk); @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_idx"}, scan_idx, 0);
    chk({name, "_vld"}, key_valid, 0);
    chk({name, "_code"}, key_code, 0);
    chk({name, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base_acc, base_vld, base_ovf;
    repeat (2) @(negedge clk);
    run = 1;
    chk_reset_vals("t1_reset");
    #2 reset = 1'b0;

    // 1: idle scanning sequence
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      chk("t1_idx", scan_idx, (k / 4) % 16);
    end
    chk("t1_vld_count", n_vld, 0);

    // 2: key 5 held, latency to 3rd slot-5 sample, single event
    key_ready = 1'b1;
    restart(16'h0020);
    base_acc = n_acc;
    t = 0;
    while (!key_valid && t < 400) begin
      @(posedge clk); t++; #1;
    end
    chk("t2_latency", t, 152);
    chk("t2_code", key_code, 5);
    @(posedge clk); #1;
    chk("t2_drop", key_valid, 0);
    scans(3);
    pressed = '0;
    scans(4);
    chk("t2_events", n_acc - base_acc, 1);
    chk("t2_acc_code", acc_code, 5);

    // 3: glitch on key 9, then steady key 2
    restart(16'h0000);
    base_vld = n_vld; base_acc = n_acc;
    pressed[9] = 1'b1; scans(1); pressed = '0; scans(3);
    chk("t3_no_event", n_vld - base_vld, 0);
    pressed[2] = 1'b1; scans(4);
    chk("t3_events", n_acc - base_acc, 1);
    chk("t3_code", acc_code, 2);
    pressed = '0; scans(4);

    // 4: output blocked; second key overflows
    key_ready = 1'b0;
    restart(16'h0000);
    base_ovf = n_ovf;
    pressed[3] = 1'b1; scans(4); pressed = '0; scans(4);
    pressed[12] = 1'b1; scans(4);
    chk("t4_vld", key_valid, 1);
    chk("t4_code", key_code, 3);
    chk("t4_ovf_count", n_ovf - base_ovf, 1);
    base_acc = n_acc;
    @(negedge clk); key_ready = 1'b1;
    @(negedge clk); key_ready = 1'b0;
    chk("t4_consumed", n_acc - base_acc, 1);
    chk("t4_acc_code", acc_code, 3);
    scans(2);
    chk("t4_no_12", key_valid, 0);
    pressed = '0; scans(4);

    // 5: accept and emit on the same edge
    restart(16'h0008);
    scans(4); pressed = '0; scans(4);
    chk("t5_pending", key_code, 3);
    pressed[7] = 1'b1;
    t = 0;
    while (!(m.tmr == SD - 1 && m.idx == 7 && m.trk == 7 && !m.conf && m.streak == DB - 1 && key_sense)
           && t < 2000) begin
      @(negedge clk); t++;
    end
    chk("t5_reached", t < 2000, 1);
    key_ready = 1'b1;
    @(negedge clk); key_ready = 1'b0;
    chk("t5_vld", key_valid, 1);
    chk("t5_code", key_code, 7);
    chk("t5_ovf", overflow, 0);
    pressed = '0; key_ready = 1'b1; scans(4);

    // 6: en freeze mid-slot, then reset mid-CONFIRM
    restart(16'h0000);
    @(posedge clk); @(posedge clk); @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_frozen", scan_idx, 0);
    en = 1'b1;
    @(posedge clk); #1 chk("t6_resume0", scan_idx, 0);
    @(posedge clk); #1 chk("t6_resume1", scan_idx, 1);
    pressed[4] = 1'b1;
    t = 0;
    while (!(m.trk == 4 && !m.conf) && t < 500) begin
      @(negedge clk); t++;
    end
    chk("t6_confirm", t < 500, 1);
    @(posedge clk); #2 reset = 1'b1; pressed = '0;
    #1 chk_reset_vals("t6_async");
    @(negedge clk); #2 reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t6_restart_idx", scan_idx, (k / 4) % 16);
    end

    // Randomized traffic
    for (int ep = 0; ep < 60; ep++) begin
      int r, len;
      bit rdy_on;
      r = $urandom_range(0, 9);
      pressed = '0;
      if (r >= 3) pressed[$urandom_range(0, 15)] = 1'b1;
      if (r >= 8) pressed[$urandom_range(0, 15)] = 1'b1;
      rdy_on = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 5) * SCAN + $urandom_range(0, SCAN - 1);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        key_ready = rdy_on && ($urandom_range(0, 3) != 0);
        en = ($urandom_range(0, 15) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #3 reset = 1'b1;
        #1 chk_reset_vals("rnd_async");
        @(negedge clk); #2 reset = 1'b0;
      end
    end

    en = 1'b1; key_ready = 1'b1; pressed = '0;
    scans(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_scan_16.md
Name: key_scan_16

Overview:
Scanner for a 16-key switch matrix. It drives a 4-bit scan index into the 4-to-16 decoder, whose one-hot output strobes one key per slot. It samples the single returned sense line, debounces one key at a time, and reports press events as a 4-bit key code on a valid/ready handshake. It sits directly upstream of the decoder and downstream of the board key matrix.

Parameters:
SCAN_DIV, 1000, clock cycles per scan slot (one key); legal range >= 4.
DB_SCANS, 4, consecutive consistent samples of the same key needed to accept a press or a release; legal range >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  scan enable; 0 freezes the slot timer and scan_idx, and takes no samples.
key_sense  input  1  1 = currently strobed key is pressed; asynchronous to clk.
scan_idx  output  4  index of the key being strobed; drives the decoder's 4-bit input.
key_code  output  4  index of the accepted key.
key_valid  output  1  key_code holds an unconsumed event.
key_ready  input  1  consumer accepts the event.
overflow  output  1  one-cycle pulse: an event was dropped because the output was occupied.

Behaviour:
- Reset values: scan_idx=0, key_code=0, key_valid=0, overflow=0, slot timer=0, FSM=IDLE, debounce count=0, captured index=0, synchronizer flops=0.
- Reset is asynchronous. Asserting it mid-operation (any FSM state, pending event) returns all state to the reset values immediately; any pending event is lost.
- key_sense passes through a 2-flop synchronizer; only the synchronized value (ks) is used.
- Slot timer counts 0..SCAN_DIV-1 while en=1.
  - At terminal count: ks is sampled for the current scan_idx, the timer goes to 0, and scan_idx increments modulo 16 (15 -> 0).
  - Sampling at the slot end with SCAN_DIV >= 4 guarantees the sample reflects the current strobe.
- en=0: timer, scan_idx and FSM hold; no samples are taken. The handshake still operates.
- FSM (evaluated only on a sample event; cnt and cap are registers):
  - IDLE: sample=1 -> cap<=scan_idx, cnt<=1. If DB_SCANS=1, emit cap and go to HELD; else go to CONFIRM. sample=0 -> stay.
  - CONFIRM: samples for other indices are ignored. Sample for cap =1 -> cnt+1; when it reaches DB_SCANS, emit cap and go to HELD. Sample for cap =0 -> IDLE.
  - HELD: other indices ignored. Sample for cap =0 -> cnt<=1; if DB_SCANS=1 go to IDLE, else go to RELEASE. Sample for cap =1 -> stay.
  - RELEASE: other indices ignored. Sample for cap =0 -> cnt+1; at DB_SCANS go to IDLE. Sample for cap =1 -> HELD.
- Only one key is tracked at a time. Other keys pressed while the FSM is not IDLE are never reported unless still pressed after return to IDLE.
- Emit: on the cycle after the emitting sample, key_valid=1 and key_code=cap.
- Handshake:
  - key_valid stays 1 and key_code stays stable until a clock edge with key_valid & key_ready; key_valid is 0 after that edge.
  - key_ready while key_valid=0 has no effect.
- Simultaneous accept and emit in one cycle: load the new code, keep key_valid=1, no overflow.
- Emit while key_valid=1 and key_ready=0: new event dropped, key_code unchanged, overflow=1 for exactly one cycle. The FSM still advances to HELD.
- Latency (key held continuously): event appears 1 cycle after the DB_SCANS-th slot-end sample of that key, i.e. about (DB_SCANS-1)*16*SCAN_DIV cycles after the first sample.

Test Plan:
1. SCAN_DIV=4. Reset, en=1, key_sense=0 -> all outputs 0; scan_idx steps 0,1,...,15,0 every 4 cycles; key_valid never asserts.
2. SCAN_DIV=4, DB_SCANS=3. key_sense=1 only while scan_idx==5, held 5 scans, key_ready=1 -> exactly one event, key_code=5; key_valid rises 1 cycle after the 3rd slot-5 sample and drops after one cycle.
3. Key 9 pressed for 1 scan then released -> no event; FSM back in IDLE. A subsequent steady press of key 2 is reported as code 2.
4. key_ready=0; press and release key 3, then press key 12 (each held 3+ scans) -> key_valid=1 with key_code=3 throughout; overflow pulses once when key 12 confirms. key_ready=1 -> code 3 consumed; no code 12 event.
5. Event emitted in the same cycle key_ready consumes a prior event -> key_valid stays 1, key_code updates to the new value, overflow=0.
6. en=0 mid-slot -> scan_idx and timer frozen, no event progress. Reset asserted mid-CONFIRM -> immediate return to reset values; after release, scanning restarts at scan_idx=0.
